decode_regfile_scoreboard: RTL

- Parametrised successor to the decode-stage register access: a multi-read-port register file with write-through bypass, a per-register busy scoreboard and registered read outputs.
- Sits in the decoding stage between instruction decode and the execution pipeline register.
- Reports RAW and WAW hazards to the stall logic and presents operand data one cycle after address.

---
 rtl/riscv_decode_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 rtl/decode_regfile_scoreboard.sv | 108 ++++++++++
 3 files changed

// File: rtl/riscv_decode_pkg.sv
// Shared decode-stage definitions: parameter defaults, the hardwired zero
// register index and the hazard-cause encoding seen by the stall controller.
package riscv_decode_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_COUNT_DEFAULT = 32;

    // Architectural register that always reads zero and ignores writes.
    localparam int ZERO_REG = 0;

    // Why the decode stage is requesting a stall.
    typedef enum logic [1:0] {
        HZ_NONE    = 2'b00,
        HZ_RAW     = 2'b01,
        HZ_WAW     = 2'b10,
        HZ_RAW_WAW = 2'b11
    } hazard_cause_e;

    // Fold the individual read-after-write and write-after-write terms into
    // the cause encoding.
    function automatic hazard_cause_e hazard_cause(input logic raw, input logic waw);
        return hazard_cause_e'({waw, raw});
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: set by an accepted issue, cleared by write-back.
// Produces the per-port busy status and the combined stall request.
//
// Issue acceptance: an issue with issue_valid_i is taken on the rising edge
// only when hazard_o, stall_i and clear_i are all low and the destination is
// not the zero register; otherwise it is dropped with no side effect and the
// decoder must present it again.
module regfile_scoreboard
    import riscv_decode_pkg::*;
#(
    parameter int REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             stall_i,
    input  logic                             clear_i,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rs_address_i,
    input  logic [READ_PORTS-1:0]            rs_use_i,
    output logic [READ_PORTS-1:0]            rs_busy_o,
    input  logic                             issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]            issue_rd_i,
    output logic                             hazard_o,
    output hazard_cause_e                    hazard_cause_o,
    input  logic                             wb_en_i,
    input  logic [ADDR_WIDTH-1:0]            wb_addr_i
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic                 raw_hit;
    logic                 waw_hit;
    logic                 issue_accept;
    logic                 wb_valid;

    // Busy lookup: the zero register and out-of-range indices are never busy.
    function automatic logic busy_of(input logic [REG_COUNT-1:0] vec,
                                     input logic [ADDR_WIDTH-1:0] addr);
        if (addr == ZERO_ADDR || int'(addr) >= REG_COUNT) begin
            return 1'b0;
        end
        return vec[addr];
    endfunction

    // A write-back landing this cycle hides the busy bit only when forwarding
    // can supply the data in the same cycle.
    function automatic logic wb_override(input logic [ADDR_WIDTH-1:0] addr);
        return (BYPASS != 0) && wb_en_i && (wb_addr_i == addr);
    endfunction

    assign wb_valid = wb_en_i && (wb_addr_i != ZERO_ADDR) && (int'(wb_addr_i) < REG_COUNT);

    // Per-port busy status and the read-after-write term.
    always_comb begin
        rs_busy_o = '0;
        raw_hit   = 1'b0;
        for (int k = 0; k < READ_PORTS; k++) begin
            rs_busy_o[k] = busy_of(busy_q, rs_address_i[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
                           !wb_override(rs_address_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
            raw_hit      = raw_hit || (rs_use_i[k] && rs_busy_o[k]);
        end
    end

    // Write-after-write term: only one outstanding writer per register.
    always_comb begin
        waw_hit = issue_valid_i && (issue_rd_i != ZERO_ADDR) &&
                  busy_of(busy_q, issue_rd_i) && !wb_override(issue_rd_i);
    end

    assign hazard_cause_o = hazard_cause(raw_hit, waw_hit);
    assign hazard_o       = (hazard_cause_o != HZ_NONE);

    assign issue_accept = issue_valid_i && !hazard_o && !stall_i && !clear_i &&
                          (issue_rd_i != ZERO_ADDR) && (int'(issue_rd_i) < REG_COUNT);

    // Next busy vector: write-back clears first so a same-register issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Busy vector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/decode_regfile_scoreboard.sv
// Decode-stage register file: multi-port reads with optional write-through
// forwarding, registered operand outputs and a busy scoreboard that raises
// the stall request for RAW and WAW hazards.
module decode_regfile_scoreboard
    import riscv_decode_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             STALL,
    input  logic                             CLEAR,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] RS_ADDRESS,
    input  logic [READ_PORTS-1:0]            RS_USE,
    output logic [READ_PORTS*XLEN-1:0]       RS_DATA,
    output logic [READ_PORTS-1:0]            RS_BUSY,
    input  logic                             ISSUE_VALID,
    input  logic [ADDR_WIDTH-1:0]            ISSUE_RD,
    output logic                             HAZARD,
    input  logic                             RD_WRITE_ENABLE,
    input  logic [ADDR_WIDTH-1:0]            RD_ADDRESS,
    input  logic [XLEN-1:0]                  RD_DATA
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic            wr_valid;
    hazard_cause_e   hazard_cause;

    assign wr_valid = RD_WRITE_ENABLE && (RD_ADDRESS != ZERO_ADDR) &&
                      (int'(RD_ADDRESS) < REG_COUNT);

    // Register storage; the zero register is never written so it stays 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[RD_ADDRESS] <= RD_DATA;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]       read_d;
        logic [XLEN-1:0]       data_q;

        assign addr = RS_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: zero register, then same-cycle forwarding, then storage.
        always_comb begin
            read_d = '0;
            if (addr == ZERO_ADDR) begin
                read_d = '0;
            end else if ((BYPASS != 0) && RD_WRITE_ENABLE && (RD_ADDRESS == addr)) begin
                read_d = RD_DATA;
            end else if (int'(addr) < REG_COUNT) begin
                read_d = regs_q[addr];
            end
        end

        // Operand output register: flush beats hold, hold beats capture.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                data_q <= '0;
            end else if (CLEAR) begin
                data_q <= '0;
            end else if (!STALL) begin
                data_q <= read_d;
            end
        end

        assign RS_DATA[k*XLEN +: XLEN] = data_q;
    end

    regfile_scoreboard #(
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk            (CLK),
        .rst_n          (RST_N),
        .stall_i        (STALL),
        .clear_i        (CLEAR),
        .rs_address_i   (RS_ADDRESS),
        .rs_use_i       (RS_USE),
        .rs_busy_o      (RS_BUSY),
        .issue_valid_i  (ISSUE_VALID),
        .issue_rd_i     (ISSUE_RD),
        .hazard_o       (HAZARD),
        .hazard_cause_o (hazard_cause),
        .wb_en_i        (RD_WRITE_ENABLE),
        .wb_addr_i      (RD_ADDRESS)
    );

    // The cause code is carried for the stall controller; the boolean request
    // is what leaves this block.
    logic unused_cause;
    assign unused_cause = ^hazard_cause;

endmodule
